// File: rtl/seq_wide_adder_if.sv
// Request/response bundle for the sequential wide adder.
// The master drives operands and the result handshake, and the slave returns the result.
interface seq_wide_adder_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  carry_in;
  logic                  sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry_out;
  logic                  overflow;

  modport master (
    output in_valid, op_a, op_b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, op_a, op_b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/seq_wide_adder.sv
// Multi-cycle add/subtract unit that processes one SLICE_WIDTH slice per clock.
// Each slice is computed by a two-level carry-lookahead adder built from 4-bit groups.
module seq_wide_adder #(
  parameter int DATA_WIDTH  = 64,
  parameter int SLICE_WIDTH = 16
) (
  input logic             clk,
  input logic             rst_n,
  seq_wide_adder_if.slave bus
);

  localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
  localparam int NGROUP = SLICE_WIDTH / 4;
  localparam int CNT_W  = (NSLICE > 2) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  // The slice adder is assembled from whole 4-bit lookahead groups.
  generate
    if ((DATA_WIDTH % SLICE_WIDTH) != 0 || NSLICE < 2 ||
        (SLICE_WIDTH % 4) != 0 || SLICE_WIDTH < 4) begin : gen_bad_params
      $error("seq_wide_adder: illegal DATA_WIDTH/SLICE_WIDTH combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] opA_q, opA_d;
  logic [DATA_WIDTH-1:0] opB_q, opB_d;
  logic                  carry_q, carry_d;
  logic [CNT_W-1:0]      sliceIdx_q, sliceIdx_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  carryOut_q, carryOut_d;
  logic                  overflow_q, overflow_d;

  logic [SLICE_WIDTH-1:0] sliceA, sliceB;
  logic [SLICE_WIDTH-1:0] bitG, bitP, bitC;
  logic [SLICE_WIDTH-1:0] sliceSum;
  logic [NGROUP-1:0]      grpG, grpP;
  logic [NGROUP:0]        grpCin;
  logic                   sliceCout;
  logic                   carryIntoMsb;

  // Every carry is written as a flat sum of products over generate/propagate terms,
  // first across the groups and then across the bits inside each group.
  always_comb begin : sliceCla
    logic acc;
    logic prod;
    acc    = 1'b0;
    prod   = 1'b1;
    sliceA = opA_q[int'(sliceIdx_q)*SLICE_WIDTH +: SLICE_WIDTH];
    sliceB = opB_q[int'(sliceIdx_q)*SLICE_WIDTH +: SLICE_WIDTH];
    bitG   = sliceA & sliceB;
    bitP   = sliceA ^ sliceB;
    grpG   = '0;
    grpP   = '0;
    grpCin = '0;
    bitC   = '0;
    for (int j = 0; j < NGROUP; j++) begin
      grpP[j] = &bitP[4*j +: 4];
      grpG[j] = bitG[4*j+3]
              | (bitP[4*j+3] & bitG[4*j+2])
              | (bitP[4*j+3] & bitP[4*j+2] & bitG[4*j+1])
              | ((&bitP[4*j+1 +: 3]) & bitG[4*j]);
    end
    grpCin[0] = carry_q;
    for (int j = 1; j <= NGROUP; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        acc  = acc | (grpG[m] & prod);
        prod = prod & grpP[m];
      end
      grpCin[j] = acc | (prod & carry_q);
    end
    for (int j = 0; j < NGROUP; j++) begin
      for (int i = 0; i < 4; i++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int m = i - 1; m >= 0; m--) begin
          acc  = acc | (bitG[4*j+m] & prod);
          prod = prod & bitP[4*j+m];
        end
        bitC[4*j+i] = acc | (prod & grpCin[j]);
      end
    end
    sliceSum     = bitP ^ bitC;
    sliceCout    = grpCin[NGROUP];
    carryIntoMsb = bitC[SLICE_WIDTH-1];
  end

  // Slices accumulate in a work register, and the visible result updates only
  // when the last slice completes, so outputs hold the previous result meanwhile.
  always_comb begin : fsmNext
    state_d       = state_q;
    opA_d         = opA_q;
    opB_d         = opB_q;
    carry_d       = carry_q;
    sliceIdx_d    = sliceIdx_q;
    work_d        = work_q;
    sum_d         = sum_q;
    carryOut_d    = carryOut_q;
    overflow_d    = overflow_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          opA_d      = bus.op_a;
          opB_d      = bus.op_b ^ {DATA_WIDTH{bus.sub}};
          carry_d    = bus.carry_in ^ bus.sub;
          sliceIdx_d = '0;
          state_d    = CALC;
        end
      end
      CALC: begin
        work_d[int'(sliceIdx_q)*SLICE_WIDTH +: SLICE_WIDTH] = sliceSum;
        carry_d    = sliceCout;
        sliceIdx_d = sliceIdx_q + CNT_W'(1);
        if (sliceIdx_q == LAST_SLICE) begin
          sum_d      = work_d;
          carryOut_d = sliceCout;
          overflow_d = carryIntoMsb ^ sliceCout;
          state_d    = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      carry_q    <= 1'b0;
      sliceIdx_q <= '0;
      work_q     <= '0;
      sum_q      <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      carry_q    <= carry_d;
      sliceIdx_q <= sliceIdx_d;
      work_q     <= work_d;
      sum_q      <= sum_d;
      carryOut_q <= carryOut_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry_out = carryOut_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_wide_adder.sv
// Directed and randomized checks of seq_wide_adder: latency, carry/overflow flags,
// backpressure, reset abandonment and in-order results under random handshakes.
module tb_seq_wide_adder;

  localparam int DW = 64;
  localparam int NUM_RANDOM = 40;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   mismatchCount;

  typedef struct {
    logic [DW-1:0] s;
    logic          c;
    logic          o;
  } expect_t;

  expect_t expectQ[$];

  seq_wide_adder_if #(.DATA_WIDTH(DW)) bus ();

  seq_wide_adder #(
    .DATA_WIDTH (DW),
    .SLICE_WIDTH(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic uses exact wide integers rather than the adder's carry structure.
  task automatic computeExpected(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic cin, input logic s, output expect_t e);
    logic [DW:0]          wide;
    logic signed [DW+1:0] exact;
    if (!s) begin
      wide  = {1'b0, a} + {1'b0, b} + (DW+1)'(cin);
      e.s   = wide[DW-1:0];
      e.c   = wide[DW];
      exact = {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b} + (DW+2)'(cin);
    end else begin
      e.s   = a - b - DW'(cin);
      e.c   = ({1'b0, a} >= ({1'b0, b} + (DW+1)'(cin)));
      exact = {{2{a[DW-1]}}, a} - {{2{b[DW-1]}}, b} - (DW+2)'(cin);
    end
    e.o = exact[DW] ^ exact[DW-1];
  endtask

  // Runs one operation from acceptance to drain, holding out_ready low for holdCycles.
  task automatic applyStimulus(input string tag, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic cin, input logic s,
                               input logic [DW-1:0] expSum, input logic expCout,
                               input logic expOvf, input int holdCycles);
    int latency;
    checkOutput({tag, "_ready_idle"}, DW'(bus.in_ready), DW'(1));
    bus.op_a     = a;
    bus.op_b     = b;
    bus.carry_in = cin;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a     = ~a;
    bus.op_b     = ~b;
    bus.carry_in = ~cin;
    bus.sub      = ~s;
    latency      = 0;
    while (!bus.out_valid && latency < 20) begin
      @(posedge clk);
      #1;
      latency++;
    end
    checkOutput({tag, "_latency"}, DW'(latency), DW'(4));
    checkOutput({tag, "_sum"}, bus.sum, expSum);
    checkOutput({tag, "_cout"}, DW'(bus.carry_out), DW'(expCout));
    checkOutput({tag, "_ovf"}, DW'(bus.overflow), DW'(expOvf));
    checkOutput({tag, "_ready_busy"}, DW'(bus.in_ready), DW'(0));
    for (int i = 0; i < holdCycles; i++) begin
      bus.in_valid = 1'b1;
      bus.op_a     = DW'(i + 3);
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, DW'(bus.out_valid), DW'(1));
      checkOutput({tag, "_hold_sum"}, bus.sum, expSum);
      checkOutput({tag, "_hold_ready"}, DW'(bus.in_ready), DW'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_drain_valid"}, DW'(bus.out_valid), DW'(0));
    checkOutput({tag, "_drain_ready"}, DW'(bus.in_ready), DW'(1));
    checkOutput({tag, "_kept_sum"}, bus.sum, expSum);
    checkOutput({tag, "_kept_cout"}, DW'(bus.carry_out), DW'(expCout));
  endtask

  initial begin
    logic    sawValid;
    int      issued;
    int      received;
    expect_t e;
    expect_t got;
    compareCount  = 0;
    mismatchCount = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;
    #2;
    checkOutput("rst_valid", DW'(bus.out_valid), DW'(0));
    checkOutput("rst_sum", bus.sum, DW'(0));
    checkOutput("rst_cout", DW'(bus.carry_out), DW'(0));
    checkOutput("rst_ovf", DW'(bus.overflow), DW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                  64'h0, 1'b1, 1'b0, 0);
    applyStimulus("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
    applyStimulus("carry_chain", 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                  64'h0001_0000_0000_0000, 1'b0, 1'b0, 0);
    applyStimulus("backpressure", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 3);
    applyStimulus("sub_equal", 64'h1234, 64'h1234, 1'b0, 1'b1,
                  64'h0, 1'b1, 1'b0, 0);
    applyStimulus("sub_borrow", 64'h5, 64'h7, 1'b1, 1'b1,
                  64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1);

    // Abandon an operation part-way through its slices.
    bus.op_a     = 64'hAAAA_AAAA_AAAA_AAAA;
    bus.op_b     = 64'h5555_5555_5555_5555;
    bus.carry_in = 1'b0;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", DW'(bus.out_valid), DW'(0));
    checkOutput("midrst_sum", bus.sum, DW'(0));
    checkOutput("midrst_cout", DW'(bus.carry_out), DW'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      sawValid = sawValid | bus.out_valid;
    end
    checkOutput("midrst_no_result", DW'(sawValid), DW'(0));
    applyStimulus("after_rst", 64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0, 0);

    issued   = 0;
    received = 0;
    for (int cyc = 0; cyc < 4000 && received < NUM_RANDOM; cyc++) begin
      if (issued < NUM_RANDOM && $urandom_range(0, 1) == 1) begin
        bus.op_a     = {$urandom(), $urandom()};
        bus.op_b     = ($urandom_range(0, 3) == 0) ? ~bus.op_a : {$urandom(), $urandom()};
        bus.carry_in = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (bus.in_valid && bus.in_ready) begin
        computeExpected(bus.op_a, bus.op_b, bus.carry_in, bus.sub, e);
        expectQ.push_back(e);
        issued++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("rnd_has_expect", DW'(expectQ.size() > 0), DW'(1));
        if (expectQ.size() > 0) begin
          got = expectQ.pop_front();
          checkOutput("rnd_sum", bus.sum, got.s);
          checkOutput("rnd_cout", DW'(bus.carry_out), DW'(got.c));
          checkOutput("rnd_ovf", DW'(bus.overflow), DW'(got.o));
        end
        received++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checkOutput("rnd_received", DW'(received), DW'(NUM_RANDOM));
    checkOutput("rnd_leftover", DW'(expectQ.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/seq_wide_adder.md
SEQ_WIDE_ADDER -- requirements
Module: seq_wide_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter SLICE_WIDTH, default 16: bits added per cycle by the internal carry-lookahead slice.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request carries a valid operation.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op_a  input  DATA_WIDTH  first operand.
REQ-008 op_b  input  DATA_WIDTH  second operand.
REQ-009 carry_in  input  1  carry-in for add; borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  DATA_WIDTH  result.
REQ-014 carry_out  output  1  raw carry out of the MSB.
REQ-015 overflow  output  1  two's-complement signed overflow.

Function
REQ-016 NSLICE = DATA_WIDTH/SLICE_WIDTH; DATA_WIDTH not an integer multiple of SLICE_WIDTH, or NSLICE < 2, is illegal and shall be flagged at elaboration.
REQ-017 FSM states: IDLE, CALC, DONE; in_ready shall be 1 only in IDLE.
REQ-018 IDLE -> CALC on in_valid && in_ready: capture op_a, op_b ^ {DATA_WIDTH{sub}}, sub, and initial carry = carry_in ^ sub; clear the slice counter to 0.
REQ-019 CALC, each cycle: add slice k (bits k*SLICE_WIDTH+SLICE_WIDTH-1 : k*SLICE_WIDTH) of the captured operands plus the carry register; write the slice result into the sum register; update the carry register; increment k.
REQ-020 Slice addition shall use 4-bit group generate/propagate with lookahead carry combination, not a ripple chain across the slice.
REQ-021 CALC -> DONE after slice NSLICE-1; carry_out = final carry; overflow = carry into MSB XOR carry out of MSB.
REQ-022 Latency: out_valid shall rise exactly NSLICE rising edges after the accepting edge (4 for defaults).
REQ-023 DONE: out_valid = 1; sum, carry_out and overflow stable; DONE -> IDLE on out_ready; in_ready is 1 on the following cycle (no same-cycle input/output overlap).
REQ-024 out_ready held low in DONE: remain in DONE indefinitely with outputs unchanged.
REQ-025 in_valid outside IDLE shall be ignored; operand changes during CALC/DONE shall not affect the result.
REQ-026 sum, carry_out and overflow shall hold the last result after DONE -> IDLE until the next result overwrites them.
REQ-027 Subtract semantics: result = op_a - op_b - carry_in (mod 2^DATA_WIDTH); carry_out = 1 means no borrow.

Reset
REQ-028 rst_n low shall immediately force: state IDLE, in_ready 1 (once released), out_valid 0, sum 0, carry_out 0, overflow 0, slice counter 0, carry register 0.
REQ-029 Reset asserted in CALC or DONE shall abandon the operation; no result shall be produced after release.

Verification
REQ-030 Add: op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0x1, carry_in=0, sub=0 -> sum=0, carry_out=1, overflow=0, out_valid 4 edges after accept.
REQ-031 Sub: op_a=0x8000_0000_0000_0000, op_b=0x1, carry_in=0, sub=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, carry_out=1, overflow=1.
REQ-032 Carry chain: op_a=0x0000_FFFF_FFFF_FFFF, op_b=0x0, carry_in=1 -> sum=0x0001_0000_0000_0000, carry_out=0; carry propagates across 3 slice boundaries.
REQ-033 Backpressure: out_ready low for 3 cycles in DONE -> out_valid and sum held constant; in_ready=0; in_valid pulses ignored; in_ready=1 the cycle after out_ready.
REQ-034 Reset mid-CALC: rst_n low at slice 2 -> out_valid=0, sum=0 immediately; after release, new request 5+7 -> sum=12 with normal latency.
REQ-035 Random back-to-back add/sub with random in_valid/out_ready -> every result matches reference model, one result per accepted request, in order.
